bpi_cmd_arbiter: RTL and testbench

Shares the BPI flash sequencer between two command sources: the JTAG user command path (J) and the internal configuration-restore engine (A). Arbitrates between them, classifies each 5-bit BPI command into the sequencer's start strobes, and completes the sequencer's Complete/NoOp handshake. Also guards every launched command with a watchdog timeout. Sits directly in front of the BPI sequencer FSM in the BPI interface.

---
 rtl/bpi_cmd_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bpi_cmd_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpi_cmd_arbiter.sv
`default_nettype none
// bpi_cmd_arbiter -- J/A command arbiter, start-strobe decoder and watchdog for the BPI sequencer.
// Rev 1.0
module bpi_cmd_arbiter #(
  parameter int               TMO_W   = 24,
  parameter logic [TMO_W-1:0] TMO_MAX = 24'hFFFFFF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       jreq,
  input  logic       areq,
  input  logic [4:0] jcmd,
  input  logic [4:0] acmd,
  input  logic       alock,
  output logic       jgnt,
  output logic       agnt,
  output logic       jdone,
  output logic       adone,
  input  logic       seqr_idle,
  input  logic       seq_cmplt,
  input  logic       rpt_error,
  output logic       lk_unlk,
  output logic       buf_prog,
  output logic       std_seq,
  output logic       simple_cmd,
  output logic [4:0] seq_cmnd,
  output logic       noop_seq,
  output logic       owner,
  output logic       busy,
  output logic       timeout,
  input  logic       clr_tmo
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DRAIN  = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [TMO_W-1:0] cnt, cnt_nxt;
  // rr_a: A holds round-robin priority (set after a J grant, cleared after an A grant)
  logic             rr_a, rr_a_nxt;
  logic             win_a;
  logic [4:0]       cmnd_nxt;
  logic             owner_nxt, jgnt_nxt, agnt_nxt, jdone_nxt, adone_nxt;
  logic             lk_nxt, buf_nxt, std_nxt, simple_nxt;
  logic             noop_nxt, tmo_nxt, busy_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rr_a       <= 1'b0;
      seq_cmnd   <= '0;
      owner      <= 1'b0;
      jgnt       <= 1'b0;
      agnt       <= 1'b0;
      jdone      <= 1'b0;
      adone      <= 1'b0;
      lk_unlk    <= 1'b0;
      buf_prog   <= 1'b0;
      std_seq    <= 1'b0;
      simple_cmd <= 1'b0;
      noop_seq   <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rr_a       <= rr_a_nxt;
      seq_cmnd   <= cmnd_nxt;
      owner      <= owner_nxt;
      jgnt       <= jgnt_nxt;
      agnt       <= agnt_nxt;
      jdone      <= jdone_nxt;
      adone      <= adone_nxt;
      lk_unlk    <= lk_nxt;
      buf_prog   <= buf_nxt;
      std_seq    <= std_nxt;
      simple_cmd <= simple_nxt;
      noop_seq   <= noop_nxt;
      timeout    <= tmo_nxt;
      busy       <= busy_nxt;
    end
  end

  // A wins when alone, when locked after its own grant, or when it holds round-robin priority
  assign win_a = areq & (~jreq | (owner & alock) | rr_a);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rr_a_nxt   = rr_a;
    cmnd_nxt   = seq_cmnd;
    owner_nxt  = owner;
    jgnt_nxt   = 1'b0;
    agnt_nxt   = 1'b0;
    jdone_nxt  = 1'b0;
    adone_nxt  = 1'b0;
    lk_nxt     = 1'b0;
    buf_nxt    = 1'b0;
    std_nxt    = 1'b0;
    simple_nxt = 1'b0;
    noop_nxt   = noop_seq;
    tmo_nxt    = timeout;

    case (state)
      S_IDLE: begin
        if (seqr_idle && (jreq || areq)) begin
          state_nxt = S_LAUNCH;
          owner_nxt = win_a;
          rr_a_nxt  = ~win_a;
          jgnt_nxt  = ~win_a;
          agnt_nxt  = win_a;
          cmnd_nxt  = win_a ? acmd : jcmd;
        end
      end
      S_LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
        case (seq_cmnd)
          5'h00: begin
            jdone_nxt = ~owner;
            adone_nxt = owner;
            state_nxt = S_IDLE;
          end
          5'h13, 5'h14, 5'h15:        lk_nxt     = 1'b1;
          5'h0C:                      buf_nxt    = 1'b1;
          5'h0A, 5'h0B, 5'h11, 5'h16: std_nxt    = 1'b1;
          default:                    simple_nxt = 1'b1;
        endcase
      end
      S_WAIT: begin
        if (!rpt_error) cnt_nxt = cnt + TMO_W'(1);
        if (seq_cmplt) begin
          jdone_nxt = ~owner;
          adone_nxt = owner;
          noop_nxt  = 1'b1;
          state_nxt = S_DRAIN;
        end else if (cnt == TMO_MAX) begin
          jdone_nxt = ~owner;
          adone_nxt = owner;
          noop_nxt  = 1'b1;
          tmo_nxt   = 1'b1;
          state_nxt = S_FAULT;
        end
      end
      S_DRAIN: begin
        if (seqr_idle) begin
          noop_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      S_FAULT: begin
        if (clr_tmo) begin
          tmo_nxt   = 1'b0;
          noop_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_bpi_cmd_arbiter.sv
`default_nettype none
// tb_bpi_cmd_arbiter -- randomized scoreboard bench with a transaction-level arbitration model
// and a reactive sequencer model.
module tb_bpi_cmd_arbiter;

  localparam int               TMO_W   = 24;
  localparam logic [TMO_W-1:0] TMO_MAX = 24'd16;
  localparam int               TMO_CYC = 17;

  logic       CLK = 1'b0;
  logic       RST;
  logic       jreq, areq, alock, clr_tmo;
  logic [4:0] jcmd, acmd;
  logic       jgnt, agnt, jdone, adone;
  logic       seqr_idle, seq_cmplt, rpt_error;
  logic       lk_unlk, buf_prog, std_seq, simple_cmd;
  logic [4:0] seq_cmnd;
  logic       noop_seq, owner, busy, timeout;

  always #5 CLK = ~CLK;

  bpi_cmd_arbiter #(.TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .jreq(jreq), .areq(areq), .jcmd(jcmd), .acmd(acmd), .alock(alock),
    .jgnt(jgnt), .agnt(agnt), .jdone(jdone), .adone(adone),
    .seqr_idle(seqr_idle), .seq_cmplt(seq_cmplt), .rpt_error(rpt_error),
    .lk_unlk(lk_unlk), .buf_prog(buf_prog), .std_seq(std_seq), .simple_cmd(simple_cmd),
    .seq_cmnd(seq_cmnd), .noop_seq(noop_seq), .owner(owner), .busy(busy),
    .timeout(timeout), .clr_tmo(clr_tmo)
  );

  typedef struct packed { logic who; logic [4:0] cmd; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_g;       // 0 none since reset, 1 J, 2 A
  bit j_pend, a_pend, hang;
  int exp_frozen;
  int cmplt_cyc;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected start strobe {lk_unlk, buf_prog, std_seq, simple_cmd} for a command
  function automatic logic [3:0] classify(input logic [4:0] c);
    if (c == 5'h00) return 4'b0000;
    if (c >= 5'h13 && c <= 5'h15) return 4'b1000;
    if (c == 5'h0C) return 4'b0100;
    if (c == 5'h0A || c == 5'h0B || c == 5'h11 || c == 5'h16) return 4'b0010;
    return 4'b0001;
  endfunction

  function automatic logic [31:0] outs();
    return {15'd0, jgnt, agnt, jdone, adone, lk_unlk, buf_prog, std_seq, simple_cmd,
            seq_cmnd, noop_seq, owner, busy, timeout};
  endfunction

  function automatic bit model_pick_a(input bit jp, input bit ap, input bit al);
    if (!ap) return 1'b0;
    if (!jp) return 1'b1;
    if (last_g == 2 && al) return 1'b1;
    return (last_g == 1);
  endfunction

  function automatic logic [4:0] rand_cmd();
    logic [4:0] lst [10] = '{5'h00, 5'h05, 5'h0A, 5'h0B, 5'h0C, 5'h11, 5'h13, 5'h14, 5'h15, 5'h16};
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return lst[$urandom_range(0, 9)];
  endfunction

  // Sequencer model
  initial begin
    seq_cmplt = 1'b0; rpt_error = 1'b0; seqr_idle = 1'b1;
    forever begin
      @(negedge CLK);
      if (!RST && (lk_unlk | buf_prog | std_seq | simple_cmd)) begin
        if (hang) begin
          if (exp_frozen != 0) begin
            repeat (2) @(negedge CLK);
            rpt_error = 1'b1;
            repeat (exp_frozen) @(negedge CLK);
            rpt_error = 1'b0;
          end
        end else begin
          seqr_idle = 1'b0;
          repeat ($urandom_range(1, 12)) @(negedge CLK);
          seq_cmplt = 1'b1;
          cmplt_cyc = cyc;
          @(negedge CLK);
          seq_cmplt = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          seqr_idle = 1'b1;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [3:0] stb, cur_cls;
    logic       cur_who, prev_tmo, active;
    int         gnt_cyc, strobe_cyc;
    exp_t       e;
    cur_cls = 4'h0; cur_who = 1'b0; prev_tmo = 1'b0; active = 1'b0;
    gnt_cyc = 0; strobe_cyc = 0;
    forever begin
      @(negedge CLK);
      stb = {lk_unlk, buf_prog, std_seq, simple_cmd};
      if (RST) begin
        active = 1'b0; prev_tmo = 1'b0;
      end else begin
        if (jgnt || agnt) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_grant: got jgnt=%0b agnt=%0b expected none (cycle %0d)", jgnt, agnt, cyc);
          end else begin
            e = exp_q.pop_front();
            check("gnt_who", {jgnt, agnt}, e.who ? 2'b01 : 2'b10);
            check("gnt_cmd", seq_cmnd, e.cmd);
            check("owner", owner, e.who);
            check("busy_at_gnt", busy, 1);
            cur_who = e.who; cur_cls = classify(e.cmd); gnt_cyc = cyc; active = 1'b1;
          end
        end
        if (stb != 4'h0) begin
          check("strobe_kind", stb, active ? cur_cls : 4'h0);
          check("strobe_time", cyc, gnt_cyc + 1);
          strobe_cyc = cyc;
        end
        if (timeout && !prev_tmo) begin
          check("tmo_time", cyc, strobe_cyc + TMO_CYC + exp_frozen);
          check("tmo_done", {jdone, adone}, cur_who ? 2'b01 : 2'b10);
          check("tmo_noop_seq", noop_seq, 1);
        end
        prev_tmo = timeout;
        if (jdone || adone) begin
          check("done_who", {jdone, adone}, cur_who ? 2'b01 : 2'b10);
          if (cur_cls == 4'h0)  check("noop_done_time", cyc, gnt_cyc + 1);
          else if (hang)        check("done_with_tmo", timeout, 1);
          else begin
            check("done_time", cyc, cmplt_cyc + 1);
            check("noop_seq_at_done", noop_seq, 1);
          end
          active = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin @(negedge CLK); n++; end
    if (busy) begin
      total++; bad++;
      $display("FAIL idle_wait: busy=%0b expected 0 within 300 cycles", busy);
    end
  endtask

  task automatic expect_grant(input bit al);
    bit wa;
    wa = model_pick_a(j_pend, a_pend, al);
    exp_q.push_back('{wa, wa ? acmd : jcmd});
    last_g = wa ? 2 : 1;
  endtask

  task automatic wait_grant();
    int n = 0;
    do begin @(negedge CLK); n++; end while (!(jgnt || agnt) && n < 60);
    if (jgnt) begin jreq = 1'b0; j_pend = 1'b0; end
    else if (agnt) begin areq = 1'b0; a_pend = 1'b0; end
    else begin
      total++; bad++;
      $display("FAIL grant_wait: no grant within 60 cycles, expected one");
      jreq = 1'b0; areq = 1'b0; j_pend = 1'b0; a_pend = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic issue_round(input bit wj, input bit wa, input logic [4:0] cj,
                             input logic [4:0] ca, input bit al);
    wait_idle();
    if (wj && !j_pend) begin jreq = 1'b1; jcmd = cj; j_pend = 1'b1; end
    if (wa && !a_pend) begin areq = 1'b1; acmd = ca; a_pend = 1'b1; end
    if (!j_pend && !a_pend) begin jreq = 1'b1; jcmd = cj; j_pend = 1'b1; end
    alock = al;
    expect_grant(al);
    wait_grant();
  endtask

  task automatic drain_pending();
    for (int k = 0; k < 3 && (j_pend || a_pend); k++) issue_round(0, 0, 5'h05, 5'h05, 1'b0);
  endtask

  task automatic tmo_test(input int frz);
    int n = 0;
    drain_pending();
    wait_idle();
    hang = 1'b1; exp_frozen = frz;
    issue_round(1, 0, 5'h05, 5'h00, 1'b0);
    while (!timeout && n < 80) begin @(negedge CLK); n++; end
    check("tmo_reached", timeout, 1);
    areq = 1'b1; acmd = 5'h0C; a_pend = 1'b1;
    repeat (8) @(negedge CLK);
    check("fault_busy", busy, 1);
    check("fault_noop_seq", noop_seq, 1);
    check("fault_tmo_sticky", timeout, 1);
    hang = 1'b0;
    expect_grant(1'b0);
    clr_tmo = 1'b1;
    @(negedge CLK);
    clr_tmo = 1'b0;
    check("tmo_cleared", timeout, 0);
    check("noop_cleared", noop_seq, 0);
    check("idle_after_clr", busy, 0);
    wait_grant();
    exp_frozen = 0;
  endtask

  initial begin
    logic [4:0] sweep [5] = '{5'h00, 5'h05, 5'h0C, 5'h13, 5'h16};
    RST = 1'b1; jreq = 1'b0; areq = 1'b0; jcmd = '0; acmd = '0; alock = 1'b0; clr_tmo = 1'b0;
    hang = 1'b0; exp_frozen = 0; j_pend = 1'b0; a_pend = 1'b0; last_g = 0; cmplt_cyc = 0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", outs(), 0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_after_reset", outs(), 0);

    issue_round(1, 0, 5'h0A, 5'h00, 1'b0);
    for (int i = 0; i < 5; i++) issue_round(1, 0, sweep[i], 5'h00, 1'b0);
    for (int i = 0; i < 6; i++) issue_round(1, 1, rand_cmd(), rand_cmd(), 1'b0);
    for (int i = 0; i < 5; i++) issue_round(1, 1, rand_cmd(), rand_cmd(), 1'b1);
    for (int i = 0; i < 2; i++) issue_round(1, 1, rand_cmd(), rand_cmd(), 1'b0);
    for (int i = 0; i < 60; i++)
      issue_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_cmd(), rand_cmd(),
                  1'($urandom_range(0, 1)));

    tmo_test(0);
    tmo_test(5);

    // Reset during WAIT with both requesters pending
    drain_pending();
    wait_idle();
    hang = 1'b1;
    issue_round(1, 0, 5'h0B, 5'h00, 1'b0);
    repeat (4) @(negedge CLK);
    jreq = 1'b1; jcmd = 5'h13; j_pend = 1'b1;
    areq = 1'b1; acmd = 5'h0C; a_pend = 1'b1;
    #2 RST = 1'b1;
    @(negedge CLK);
    check("reset_mid_wait", outs(), 0);
    hang = 1'b0; last_g = 0;
    RST = 1'b0;
    issue_round(0, 0, 5'h00, 5'h00, 1'b0);
    issue_round(0, 0, 5'h00, 5'h00, 1'b0);

    wait_idle();
    repeat (5) @(negedge CLK);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
